enc32t5_pend: RTL and testbench
===============================

ENC32T5_PEND -- requirements
Module: enc32t5_pend

Interface
REQ-001 The block SHALL have the parameter PRIO_HIGH, default 1: 1 = highest pending index wins; 0 = lowest pending index wins.
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have the port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have the port en, input, 1 bit: enables issue of a new code; does not block request capture.
REQ-005 The block SHALL have the port req, input, 32 bits: one-hot or multi-hot request strobes; bit k requests code k.
REQ-006 The block SHALL have the port ack, input, 1 bit: consumer accepts the presented code; meaningful only while valid=1.
REQ-007 The block SHALL have the port code, output, 5 bits: binary index of the issued request, registered.
REQ-008 The block SHALL have the port valid, output, 1 bit: code holds an issued, unacknowledged request, registered.
REQ-009 The block SHALL have the port pend, output, 32 bits: pending-request register, direct register output.
REQ-010 The block SHALL have the port ovf, output, 1 bit: sticky flag for a dropped (coalesced) request, registered.

Function
REQ-011 The block SHALL capture requests: at each edge, pend <= (pend & ~clr) | req, where clr = onehot(code) if valid&ack, else 0.
REQ-012 A req bit asserted in the same cycle as the ack clearing that bit SHALL win: the bit stays set, and this is not an overflow.
REQ-013 The block SHALL use two states, IDLE (valid=0) and HOLD (valid=1); no other states.
REQ-014 In IDLE with en=1 and pend!=0, the block SHALL move to HOLD at the edge; code <= priority index of current pend (per PRIO_HIGH); valid <= 1.
REQ-015 In IDLE with en=0 or pend==0, the block SHALL stay in IDLE; code holds its previous value.
REQ-016 In HOLD, code SHALL be stable; a new req with higher priority SHALL NOT pre-empt the issued code.
REQ-017 In HOLD with ack=1, the block SHALL go to IDLE at the edge and clear pend[code] per REQ-011.
REQ-018 In HOLD with ack=0, the block SHALL stay in HOLD regardless of en; valid is never retracted without ack.
REQ-019 Latency SHALL be: req sampled at edge N, pend bit visible after N, code/valid after edge N+1 (en=1, IDLE, no higher pending bit).
REQ-020 Maximum issue rate SHALL be one code per 2 cycles (HOLD->IDLE->HOLD); back-to-back HOLD is not permitted.
REQ-021 The selected index SHALL come from pend before the REQ-011 update of the same edge; requests arriving that cycle are considered from the next IDLE cycle.
REQ-022 ovf SHALL set at an edge when req[k]=1 and pend[k]=1 for any k, except where REQ-012 applies; it is cleared only by rst.
REQ-023 Multi-hot req SHALL be captured in full in one cycle; issue order then follows priority, one code per issue.
REQ-024 The block SHALL have no combinational path from req or ack to any output.

Reset
REQ-025 With rst=1 at an edge: pend=0, code=0, valid=0, ovf=0, state IDLE; req/ack in that cycle are ignored.
REQ-026 rst SHALL take precedence over every other input, including an in-progress HOLD (the issued code is discarded, with no ack needed).
REQ-027 After rst deasserts, the first capture SHALL occur at the next edge.

Verification
REQ-028 Single request: PRIO_HIGH=1, en=1, req=0x0000_0020 for 1 cycle -> pend=0x20 after edge N, code=5/valid=1 after N+1, ack -> pend=0, valid=0.
REQ-029 Priority order: req=0x8000_0001 for 1 cycle, ack each issue -> codes 31 then 0; with PRIO_HIGH=0 -> codes 0 then 31; 2 cycles between issues.
REQ-030 No pre-empt / hold: issue code 3; during HOLD assert req bit 20 and en=0 -> code stays 3, valid stays 1; after ack and en=1 -> code 20 issued.
REQ-031 Ack/request collision: HOLD code 7, ack=1 with req=0x80 same cycle -> pend[7] remains 1, ovf=0, code 7 re-issued 2 cycles later; req=0x80 while pend[7]=1 without ack -> ovf=1 until rst.
REQ-032 Reset mid-operation: valid=1, pend=0xFFFF_FFFF, ovf=1, rst=1 for one edge -> all outputs 0 next cycle; req=0x10 in the reset cycle not captured.
REQ-033 en gating: en=0, req=0x0F -> pend=0x0F, valid stays 0 indefinitely; en=1 -> code 3 (PRIO_HIGH=1) after one edge.

Source files
------------

// File: rtl/enc32t5_pend.sv
// 32-to-5 priority encoder with a sticky pending-request register and a
// two-state issue/ack handshake; overflow flags requests coalesced onto a pending bit.
module enc32t5_pend #(
  parameter bit PRIO_HIGH = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] req,
  input  logic        ack,
  output logic [4:0]  code,
  output logic        valid,
  output logic [31:0] pend,
  output logic        ovf
);

  // Handshake: valid rises when a code is issued and stays high, with code
  // stable, until a cycle where ack=1 is sampled; that edge retires the code
  // and valid drops. ack is ignored while valid=0. The FSM state is valid itself.
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [4:0]  code_q;
  logic [4:0]  pick_idx;
  logic [31:0] pend_q;
  logic [31:0] clr;
  logic        ovf_q;
  logic        issue;
  logic        retire;

  // Priority select over the pending register as it stood before this edge.
  always_comb begin
    pick_idx = '0;
    if (PRIO_HIGH) begin
      for (int i = 0; i < 32; i++)
        if (pend_q[i]) pick_idx = 5'(i);
    end else begin
      for (int i = 31; i >= 0; i--)
        if (pend_q[i]) pick_idx = 5'(i);
    end
  end

  assign issue  = (state_q == IDLE) && en && (pend_q != '0);
  assign retire = (state_q == HOLD) && ack;
  assign clr    = retire ? (32'b1 << code_q) : '0;

  // State register plus the datapath registers it sequences.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      code_q  <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= (pend_q & ~clr) | req;
      if (issue)
        code_q <= pick_idx;
      // A request landing on the bit being acked this edge is a fresh request.
      if ((req & pend_q & ~clr) != '0)
        ovf_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (issue)  state_d = HOLD;
      HOLD:    if (retire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    valid = (state_q == HOLD);
    code  = code_q;
    pend  = pend_q;
    ovf   = ovf_q;
  end

endmodule

// File: tb/tb_enc32t5_pend.sv
// Bench for enc32t5_pend: both priority polarities driven in parallel,
// directed scenarios against constants plus random traffic against a reference model.
module tb_enc32t5_pend;

  logic        clk;
  logic        rst;
  logic        en;
  logic [31:0] req;
  logic        ack;

  logic [4:0]  code_hi, code_lo;
  logic        valid_hi, valid_lo;
  logic [31:0] pend_hi, pend_lo;
  logic        ovf_hi, ovf_lo;

  int checks = 0;
  int errors = 0;

  // Reference model state, index 1 = highest-wins, index 0 = lowest-wins.
  logic [31:0] m_pend  [2];
  logic [4:0]  m_code  [2];
  logic        m_valid [2];
  logic        m_ovf   [2];

  enc32t5_pend #(.PRIO_HIGH(1'b1)) dut_hi (
    .clk(clk), .rst(rst), .en(en), .req(req), .ack(ack),
    .code(code_hi), .valid(valid_hi), .pend(pend_hi), .ovf(ovf_hi)
  );

  enc32t5_pend #(.PRIO_HIGH(1'b0)) dut_lo (
    .clk(clk), .rst(rst), .en(en), .req(req), .ack(ack),
    .code(code_lo), .valid(valid_lo), .pend(pend_lo), .ovf(ovf_lo)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Winner index by arithmetic: highest set bit = floor(log2 v), lowest = log2(v & -v).
  function automatic logic [4:0] winner(input logic [31:0] v, input bit high);
    longint unsigned x;
    x = {32'b0, v};
    if (high) return 5'($clog2(x + 1) - 1);
    return 5'($clog2(x & (~x + 1)));
  endfunction

  task automatic model_step(input logic r, input logic e, input logic [31:0] q, input logic a);
    logic [31:0] retired;
    for (int p = 0; p < 2; p++) begin
      if (r) begin
        m_pend[p] = '0; m_code[p] = '0; m_valid[p] = 1'b0; m_ovf[p] = 1'b0;
      end else begin
        retired = '0;
        if (m_valid[p] && a) retired[m_code[p]] = 1'b1;
        if ((q & m_pend[p] & ~retired) != 0) m_ovf[p] = 1'b1;
        if (m_valid[p]) begin
          if (a) m_valid[p] = 1'b0;
        end else if (e && m_pend[p] != 0) begin
          m_code[p]  = winner(m_pend[p], p == 1);
          m_valid[p] = 1'b1;
        end
        m_pend[p] = (m_pend[p] & ~retired) | q;
      end
    end
  endtask

  // Driver: apply inputs, take one edge, sample 1 time unit after the edge.
  task automatic cycle(input logic r, input logic e, input logic [31:0] q, input logic a);
    rst = r; en = e; req = q; ack = a;
    @(posedge clk);
    model_step(r, e, q, a);
    #1;
  endtask

  task automatic test_reset;
    cycle(1, 0, 32'hFFFF_FFFF, 1);
    cycle(1, 1, 32'h0000_00FF, 0);
    checks++; if (pend_hi !== 32'h0) begin errors++; $display("FAIL reset_pend: got %h expected %h", pend_hi, 32'h0); end
    checks++; if (code_hi !== 5'd0) begin errors++; $display("FAIL reset_code: got %0d expected 0", code_hi); end
    checks++; if (valid_hi !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_hi); end
    checks++; if (ovf_hi !== 1'b0 || ovf_lo !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b/%b expected 0/0", ovf_hi, ovf_lo); end
  endtask

  task automatic test_single;
    cycle(1, 0, 0, 0);
    cycle(0, 1, 32'h0000_0020, 0);
    checks++; if (pend_hi !== 32'h20 || valid_hi !== 1'b0) begin errors++; $display("FAIL single_capture: got pend=%h valid=%b expected pend=00000020 valid=0", pend_hi, valid_hi); end
    cycle(0, 1, 0, 0);
    checks++; if (valid_hi !== 1'b1 || code_hi !== 5'd5) begin errors++; $display("FAIL single_issue: got valid=%b code=%0d expected valid=1 code=5", valid_hi, code_hi); end
    cycle(0, 1, 0, 1);
    checks++; if (valid_hi !== 1'b0 || pend_hi !== 32'h0) begin errors++; $display("FAIL single_ack: got valid=%b pend=%h expected valid=0 pend=0", valid_hi, pend_hi); end
  endtask

  task automatic test_priority;
    cycle(1, 0, 0, 0);
    cycle(0, 1, 32'h8000_0001, 0);
    cycle(0, 1, 0, 0);
    checks++; if (code_hi !== 5'd31 || valid_hi !== 1'b1) begin errors++; $display("FAIL prio_hi_first: got code=%0d valid=%b expected 31/1", code_hi, valid_hi); end
    checks++; if (code_lo !== 5'd0 || valid_lo !== 1'b1) begin errors++; $display("FAIL prio_lo_first: got code=%0d valid=%b expected 0/1", code_lo, valid_lo); end
    cycle(0, 1, 0, 1);
    checks++; if (valid_hi !== 1'b0 || valid_lo !== 1'b0) begin errors++; $display("FAIL prio_gap: got valid=%b/%b expected 0/0", valid_hi, valid_lo); end
    cycle(0, 1, 0, 0);
    checks++; if (code_hi !== 5'd0 || code_lo !== 5'd31 || valid_hi !== 1'b1) begin errors++; $display("FAIL prio_second: got hi=%0d lo=%0d expected hi=0 lo=31", code_hi, code_lo); end
    cycle(0, 1, 0, 1);
    checks++; if (pend_hi !== 32'h0 || pend_lo !== 32'h0) begin errors++; $display("FAIL prio_drain: got %h/%h expected 0/0", pend_hi, pend_lo); end
  endtask

  task automatic test_no_preempt;
    cycle(1, 0, 0, 0);
    cycle(0, 1, 32'h0000_0008, 0);
    cycle(0, 1, 0, 0);
    cycle(0, 0, 32'h0010_0000, 0);
    cycle(0, 0, 0, 0);
    checks++; if (code_hi !== 5'd3 || valid_hi !== 1'b1) begin errors++; $display("FAIL hold_stable: got code=%0d valid=%b expected 3/1", code_hi, valid_hi); end
    cycle(0, 1, 0, 1);
    checks++; if (valid_hi !== 1'b0 || pend_hi !== 32'h0010_0000) begin errors++; $display("FAIL hold_ack: got valid=%b pend=%h expected 0/00100000", valid_hi, pend_hi); end
    cycle(0, 1, 0, 0);
    checks++; if (code_hi !== 5'd20 || valid_hi !== 1'b1) begin errors++; $display("FAIL hold_next: got code=%0d valid=%b expected 20/1", code_hi, valid_hi); end
    cycle(0, 1, 0, 1);
  endtask

  task automatic test_collision;
    cycle(1, 0, 0, 0);
    cycle(0, 1, 32'h80, 0);
    cycle(0, 1, 0, 0);
    cycle(0, 1, 32'h80, 1);
    checks++; if (pend_hi !== 32'h80 || ovf_hi !== 1'b0 || valid_hi !== 1'b0) begin errors++; $display("FAIL collide_keep: got pend=%h ovf=%b valid=%b expected 00000080/0/0", pend_hi, ovf_hi, valid_hi); end
    cycle(0, 1, 0, 0);
    checks++; if (code_hi !== 5'd7 || valid_hi !== 1'b1) begin errors++; $display("FAIL collide_reissue: got code=%0d valid=%b expected 7/1", code_hi, valid_hi); end
    cycle(0, 1, 32'h80, 0);
    checks++; if (ovf_hi !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", ovf_hi); end
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, i == 1);
    checks++; if (ovf_hi !== 1'b1 || ovf_lo !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b/%b expected 1/1", ovf_hi, ovf_lo); end
  endtask

  task automatic test_reset_mid;
    cycle(1, 0, 0, 0);
    cycle(0, 1, 32'hFFFF_FFFF, 0);
    cycle(0, 1, 0, 0);
    cycle(0, 1, 32'hFFFF_FFFF, 0);
    checks++; if (valid_hi !== 1'b1 || pend_hi !== 32'hFFFF_FFFF || ovf_hi !== 1'b1) begin errors++; $display("FAIL mid_setup: got valid=%b pend=%h ovf=%b expected 1/ffffffff/1", valid_hi, pend_hi, ovf_hi); end
    cycle(1, 1, 32'h10, 1);
    checks++; if (valid_hi !== 1'b0 || pend_hi !== 32'h0 || ovf_hi !== 1'b0 || code_hi !== 5'd0) begin errors++; $display("FAIL mid_reset: got valid=%b pend=%h ovf=%b code=%0d expected all 0", valid_hi, pend_hi, ovf_hi, code_hi); end
    cycle(0, 1, 0, 0);
    checks++; if (pend_hi !== 32'h0 || valid_hi !== 1'b0) begin errors++; $display("FAIL mid_nocapture: got pend=%h valid=%b expected 0/0", pend_hi, valid_hi); end
  endtask

  task automatic test_en_gating;
    cycle(1, 0, 0, 0);
    cycle(0, 0, 32'h0F, 0);
    checks++; if (pend_hi !== 32'h0F) begin errors++; $display("FAIL gate_capture: got %h expected 0000000f", pend_hi); end
    for (int i = 0; i < 6; i++) begin
      cycle(0, 0, 0, 1);
      checks++; if (valid_hi !== 1'b0) begin errors++; $display("FAIL gate_idle: cycle %0d got valid=%b expected 0", i, valid_hi); end
    end
    cycle(0, 1, 0, 0);
    checks++; if (code_hi !== 5'd3 || valid_hi !== 1'b1) begin errors++; $display("FAIL gate_release: got code=%0d valid=%b expected 3/1", code_hi, valid_hi); end
  endtask

  task automatic test_random;
    logic [31:0] q;
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: q = 32'h1 << $urandom_range(0, 31);
        3:       q = $urandom;
        default: q = '0;
      endcase
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, q, $urandom_range(0, 1) == 1);
      checks++; if (pend_hi !== m_pend[1] || pend_lo !== m_pend[0]) begin errors++; $display("FAIL rand_pend: n=%0d got %h/%h expected %h/%h", n, pend_hi, pend_lo, m_pend[1], m_pend[0]); end
      checks++; if (valid_hi !== m_valid[1] || valid_lo !== m_valid[0]) begin errors++; $display("FAIL rand_valid: n=%0d got %b/%b expected %b/%b", n, valid_hi, valid_lo, m_valid[1], m_valid[0]); end
      checks++; if (code_hi !== m_code[1] || code_lo !== m_code[0]) begin errors++; $display("FAIL rand_code: n=%0d got %0d/%0d expected %0d/%0d", n, code_hi, code_lo, m_code[1], m_code[0]); end
      checks++; if (ovf_hi !== m_ovf[1] || ovf_lo !== m_ovf[0]) begin errors++; $display("FAIL rand_ovf: n=%0d got %b/%b expected %b/%b", n, ovf_hi, ovf_lo, m_ovf[1], m_ovf[0]); end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; req = '0; ack = 1'b0;
    for (int p = 0; p < 2; p++) begin
      m_pend[p] = '0; m_code[p] = '0; m_valid[p] = 1'b0; m_ovf[p] = 1'b0;
    end
    test_reset;
    test_single;
    test_priority;
    test_no_preempt;
    test_collision;
    test_reset_mid;
    test_en_gating;
    cycle(1, 0, 0, 0);
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
